// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the DDR3 client arbiter.
//   arb_state_t : arbiter FSM states
//   DDR_ADDR_W  : default command address width
//   DDR_DATA_W  : default data beat width
//   idx_width() : bits needed to index N clients (at least 1)
package ddr3_arb_pkg;

    localparam int unsigned DDR_ADDR_W = 32;
    localparam int unsigned DDR_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr3_client_arbiter_if.sv
// Command/completion bundle between the arbiter and avalon_ddr3_interface.
//   master (arbiter)  : drives sdram_address, rd_en, wr_en, write_data_input
//                       samples read_data, read_complete, write_complete
//   slave (interface) : the mirror image
interface ddr3_client_arbiter_if
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DDR_ADDR_W,
    parameter int unsigned DATA_W = DDR_DATA_W
);

    logic [ADDR_W-1:0] sdram_address;
    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] write_data_input;
    logic [DATA_W-1:0] read_data;
    logic              read_complete;
    logic              write_complete;

    modport master (
        output sdram_address,
        output rd_en,
        output wr_en,
        output write_data_input,
        input  read_data,
        input  read_complete,
        input  write_complete
    );

    modport slave (
        input  sdram_address,
        input  rd_en,
        input  wr_en,
        input  write_data_input,
        output read_data,
        output read_complete,
        output write_complete
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
//   req       : request vector, one bit per client
//   rr_ptr    : client index with highest priority this round
//   grant_idx : first requesting client at or after rr_ptr (wrapping)
//   any_req   : at least one request present
// The request vector is doubled so a single right shift by rr_ptr lines the
// wrapped priority order up at bit 0; the lowest set bit then wins.
module rr_priority_picker #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   any_req
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [2*NUM_CLIENTS-1:0] req_dbl;
    logic [2*NUM_CLIENTS-1:0] req_rot;
    logic [SUM_W-1:0]         sum;
    logic                     found;

    always_comb begin
        req_dbl   = {req, req};
        req_rot   = req_dbl >> rr_ptr;
        any_req   = |req;
        grant_idx = '0;
        sum       = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr} + SUM_W'(i);
                if (sum >= SUM_W'(NUM_CLIENTS)) begin
                    sum = sum - SUM_W'(NUM_CLIENTS);
                end
                grant_idx = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ddr3_client_arbiter.sv
// Round-robin arbiter sharing one single-command DDR3 Avalon interface among
// NUM_CLIENTS single-beat requesters.
//   clk, reset     : clock, synchronous active-high reset
//   client_req/we/addr/wdata : per-client request, held until ack
//   client_ack     : one-hot completion pulse (DONE state)
//   client_rdata   : last captured read data
//   ddr            : command port towards avalon_ddr3_interface
//   busy           : FSM not in IDLE
//   timeout_err    : sticky, completion not seen within TIMEOUT_CYCLES
//   protocol_err   : sticky, stray, wrong-type or double completion
// All outputs come from registers or decode of registered state.
module ddr3_client_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS    = 4,
    parameter int unsigned ADDR_W         = DDR_ADDR_W,
    parameter int unsigned DATA_W         = DDR_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        client_req,
    input  logic [NUM_CLIENTS-1:0]        client_we,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] client_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] client_wdata,
    output logic [NUM_CLIENTS-1:0]        client_ack,
    output logic [DATA_W-1:0]             client_rdata,
    ddr3_client_arbiter_if.master         ddr,
    output logic                          busy,
    output logic                          timeout_err,
    output logic                          protocol_err
);

    localparam int unsigned IDX_W = idx_width(NUM_CLIENTS);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              protocol_err_q, protocol_err_d;

    logic [IDX_W-1:0]  grant_idx;
    logic              any_req;
    logic              done_hit;
    logic              wrong_hit;

    rr_priority_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req       (client_req),
        .rr_ptr    (rr_ptr_q),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            rr_ptr_q       <= '0;
            wait_cnt_q     <= '0;
            timeout_err_q  <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            rr_ptr_q       <= rr_ptr_d;
            wait_cnt_q     <= wait_cnt_d;
            timeout_err_q  <= timeout_err_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        rr_ptr_d       = rr_ptr_q;
        wait_cnt_d     = wait_cnt_q;
        timeout_err_d  = timeout_err_q;
        protocol_err_d = protocol_err_q;

        done_hit  = we_q ? ddr.write_complete : ddr.read_complete;
        wrong_hit = we_q ? ddr.read_complete  : ddr.write_complete;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    idx_d   = grant_idx;
                    state_d = ISSUE;
                    for (int i = 0; i < NUM_CLIENTS; i++) begin
                        if (grant_idx == IDX_W'(i)) begin
                            we_d    = client_we[i];
                            addr_d  = client_addr[i*ADDR_W +: ADDR_W];
                            wdata_d = client_wdata[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            ISSUE: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (done_hit) begin
                    if (!we_q) begin
                        rdata_d = ddr.read_data;
                    end
                    rr_ptr_d = (idx_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : idx_q + 1'b1;
                    state_d  = DONE;
                end else if (wait_cnt_q == CNT_MAX) begin
                    // Interface cannot be aborted: flag it and keep waiting.
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != WAIT) && (ddr.read_complete || ddr.write_complete)) begin
            protocol_err_d = 1'b1;
        end
        if ((state_q == WAIT) && wrong_hit) begin
            protocol_err_d = 1'b1;
        end
        if (ddr.read_complete && ddr.write_complete) begin
            protocol_err_d = 1'b1;
        end
    end

    always_comb begin
        client_ack = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            client_ack[i] = (state_q == DONE) && (idx_q == IDX_W'(i));
        end
    end

    assign ddr.sdram_address    = addr_q;
    assign ddr.write_data_input = wdata_q;
    assign ddr.rd_en            = (state_q == ISSUE) && !we_q;
    assign ddr.wr_en            = (state_q == ISSUE) && we_q;

    assign client_rdata = rdata_q;
    assign busy         = (state_q != IDLE);
    assign timeout_err  = timeout_err_q;
    assign protocol_err = protocol_err_q;

endmodule

// File: doc/ddr3_client_arbiter.md
# ddr3_client_arbiter

Round-robin arbiter that shares the single-command DDR3 Avalon interface block (`avalon_ddr3_interface`) among several Canny-pipeline clients (frame reader, edge writer, debug port, etc.). It accepts single-beat 128-bit read/write requests from `NUM_CLIENTS` requesters and issues one command at a time on the interface's `rd_en`/`wr_en` command port. It waits for `read_complete`/`write_complete`, then returns an acknowledge and read data to the granted client. It also watches for stalled or spurious completions.

## Interface
- `NUM_CLIENTS`, 4: number of requesters, 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 128: data width.
- `TIMEOUT_CYCLES`, 1024: cycles in WAIT before `timeout_err` sets, ≥2.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `client_req` in NUM_CLIENTS: request; held until its ack.
- `client_we` in NUM_CLIENTS: 1 = write, 0 = read; stable while req.
- `client_addr` in NUM_CLIENTS×ADDR_W: per-client address; stable while req.
- `client_wdata` in NUM_CLIENTS×DATA_W: per-client write data; stable while req.
- `client_ack` out NUM_CLIENTS: one-hot, one-cycle completion pulse.
- `client_rdata` out DATA_W: shared read data, valid while `client_ack` is high for a read.
- `sdram_address` out ADDR_W: command address to interface.
- `rd_en` out 1: read command, one-cycle pulse.
- `wr_en` out 1: write command, one-cycle pulse.
- `write_data_input` out DATA_W: write data to interface.
- `read_data` in DATA_W: read data from interface.
- `read_complete` in 1: read completion pulse.
- `write_complete` in 1: write completion pulse.
- `busy` out 1: high in any state except IDLE.
- `timeout_err` out 1: sticky; cleared only by reset.
- `protocol_err` out 1: sticky; cleared only by reset.

## Operation
- **States:**
  - **IDLE:** if any `client_req`, the round-robin picker chooses the first requesting client at or after `rr_ptr` (wrapping modulo NUM_CLIENTS). Latch its index, `we`, address and wdata, then go to ISSUE. With no request, stay in IDLE.
  - **ISSUE:** drive `sdram_address`/`write_data_input` from the latched values. Assert `wr_en` if we=1, else `rd_en`, for exactly this cycle. Go to WAIT.
  - **WAIT:** hold address/data outputs; `wait_cnt` increments each cycle.
    - On the completion matching the latched `we`: capture `read_data` into `client_rdata` (reads only), set `rr_ptr` = (idx+1) mod NUM_CLIENTS, go to DONE.
  - **DONE:** `client_ack[idx]`=1 for this cycle only; go to IDLE.
- `rd_en`/`wr_en` are never asserted outside ISSUE. At most one command is outstanding.
- `client_rdata` holds its value until the next read capture; it is not updated on writes.
- `protocol_err` sets on:
  - `read_complete` or `write_complete` outside WAIT;
  - the wrong-type completion in WAIT (the arbiter ignores it and keeps waiting);
  - both completions high in the same cycle.
- `timeout_err` sets when `wait_cnt` reaches TIMEOUT_CYCLES−1 without completion. The arbiter keeps waiting because the interface cannot be aborted. `wait_cnt` saturates and is cleared on entry to WAIT.
- A client's request is ignored while another client is in flight; fairness comes only from `rr_ptr`.
- Simultaneous requests: the lowest index at or after `rr_ptr` wins.
- Reset mid-transaction:
  - State → IDLE, `rr_ptr` → 0, both error flags cleared.
  - The interface shares `reset`, so no cleanup handshake is needed.

## Timing
- Reset values:
  - `client_ack`=0, `client_rdata`=0, `rd_en`=`wr_en`=0, `sdram_address`=0, `write_data_input`=0, `busy`=0, `timeout_err`=`protocol_err`=0.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- Request in IDLE at cycle T → command pulse at T+1 → interface registers it at the end of T+1.
- Completion observed at cycle C → `client_ack` at C+1 → IDLE at C+2.
- With waitrequest=0, a write sees completion at T+2 and ack at T+3. Back-to-back grant period is 4 cycles plus interface latency.
- Client contract: keep `client_req` high through the ack cycle and deassert it on the following edge. The DONE state guarantees no re-grant of the same request.

## Structure
- Package `ddr3_arb_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT, DONE};
  - localparams `DDR_ADDR_W`=32, `DDR_DATA_W`=128.
- Sub-module `rr_priority_picker` (combinational):
  - inputs: request vector and `rr_ptr`;
  - outputs: grant index and `any_req`;
  - implemented as a doubled-vector priority scan.
- The top contains the FSM, latches, wait counter and error flags.

## Test plan
- **Single write:** client 2 with we=1, addr=0x0000_1000, wdata=0xA5…A5, `write_complete` 2 cycles after `wr_en` → one `wr_en` pulse with those values, `client_ack`=4'b0100 exactly 1 cycle after completion.
- **Single read:** client 0 read with `read_data`=0x1234…, `read_complete` delayed 10 cycles → `client_rdata`=0x1234… with `client_ack`=4'b0001; `busy` high throughout.
- **Round-robin:** all 4 clients request continuously after reset → grant order 0,1,2,3,0; no client granted twice in succession.
- **Timeout:** TIMEOUT_CYCLES=16, never complete → `timeout_err`=1 after 16 WAIT cycles, no ack, no new command. A later completion still acks and `timeout_err` stays 1.
- **Protocol error:** `write_complete` pulsed in IDLE, or `write_complete` during a read → `protocol_err`=1, FSM state unchanged.
- **Reset mid-WAIT:** reset during WAIT → next cycle all outputs at reset values, `rr_ptr`=0; a new request from client 3 is then granted normally.
